// File: rtl/range_session_ctrl.sv
// Session controller for the range-finder datapath: frames a sample burst into
// go/finish strobes, then captures and presents the range result on a valid/ready port.
module range_session_ctrl #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 255,
    parameter int TIMEOUT = 63,
    localparam int CW     = $clog2(MAX_LEN + 1),
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CW-1:0]    cfg_len,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             rf_go,
    output logic             rf_finish,
    output logic [WIDTH-1:0] rf_data,
    input  logic [WIDTH:0]   rf_range,
    input  logic             rf_error,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [WIDTH:0]   r_range,
    output logic [CW-1:0]    r_count,
    output logic             r_trunc,
    output logic             r_err
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, HOLD} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    len, len_in, count;
    logic [TW-1:0]    idle;
    logic [WIDTH-1:0] held;
    logic             trunc;
    logic             accept, last_slot, tmo;

    always_comb begin
        if (cfg_len == '0)
            len_in = CW'(1);
        else if (int'(cfg_len) > MAX_LEN)
            len_in = CW'(MAX_LEN);
        else
            len_in = cfg_len;
    end

    always_comb begin
        state_nx  = state;
        s_ready   = 1'b0;
        rf_go     = 1'b0;
        rf_finish = 1'b0;
        rf_data   = held;
        r_valid   = 1'b0;
        accept    = 1'b0;
        tmo       = 1'b0;
        last_slot = (count + CW'(1)) == len;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    accept  = 1'b1;
                    rf_go   = 1'b1;
                    rf_data = s_data;
                    if (len_in == CW'(1)) begin
                        rf_finish = 1'b1;
                        state_nx  = WAIT;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                // abort blocks new samples, except the one that would close the window anyway
                s_ready = !abort || last_slot;
                accept  = s_valid && s_ready;
                if (accept)
                    rf_data = s_data;
                tmo = !accept && (idle == TW'(TIMEOUT - 1));
                if ((accept && last_slot) || abort || tmo) begin
                    rf_finish = 1'b1;
                    state_nx  = WAIT;
                end
            end
            WAIT: state_nx = HOLD;
            HOLD: begin
                r_valid = 1'b1;
                if (r_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // strobes must vanish the instant reset rises, not at the next edge
        if (reset) begin
            s_ready   = 1'b0;
            rf_go     = 1'b0;
            rf_finish = 1'b0;
            rf_data   = '0;
            r_valid   = 1'b0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len     <= '0;
            count   <= '0;
            idle    <= '0;
            held    <= '0;
            trunc   <= 1'b0;
            r_range <= '0;
            r_count <= '0;
            r_trunc <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    len   <= len_in;
                    count <= CW'(1);
                    idle  <= '0;
                    held  <= s_data;
                    trunc <= 1'b0;
                end
                RUN: begin
                    if (accept) begin
                        held <= s_data;
                        idle <= '0;
                        if (count != len)
                            count <= count + CW'(1);
                    end else if (idle != TW'(TIMEOUT)) begin
                        idle <= idle + TW'(1);
                    end
                    if (rf_finish)
                        trunc <= abort || tmo;
                end
                WAIT: begin
                    r_range <= rf_range;
                    r_err   <= rf_error;
                    r_count <= count;
                    r_trunc <= trunc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_range_session_ctrl.sv
// Bench for range_session_ctrl: behavioural range-finder model, directed windows,
// scoreboard of hand-computed results checked by an independent monitor.
module tb_range_session_ctrl;
    localparam int WIDTH = 8, MAX_LEN = 10, TIMEOUT = 63, CW = 4;

    typedef struct packed {
        logic [WIDTH:0]  range;
        logic [CW-1:0]   count;
        logic            trunc;
        logic            err;
    } res_t;

    logic clock = 1'b0, reset = 1'b1;
    logic [CW-1:0] cfg_len = '0;
    logic abort = 1'b0, s_valid = 1'b0, s_ready;
    logic [WIDTH-1:0] s_data = '0, rf_data;
    logic rf_go, rf_finish, rf_error, r_valid, r_ready = 1'b1, r_trunc, r_err;
    logic [WIDTH:0] rf_range, r_range;
    logic [CW-1:0] r_count;

    int n_chk = 0, n_fail = 0;
    res_t sb[$];
    logic err_inject = 1'b0;

    range_session_ctrl #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .cfg_len(cfg_len), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .rf_go(rf_go), .rf_finish(rf_finish), .rf_data(rf_data),
        .rf_range(rf_range), .rf_error(rf_error),
        .r_valid(r_valid), .r_ready(r_ready), .r_range(r_range),
        .r_count(r_count), .r_trunc(r_trunc), .r_err(r_err)
    );

    always #5 clock = ~clock;

    // range-finder model: tracks min/max from go through finish, result next cycle
    logic active;
    logic [WIDTH-1:0] mn, mx, cur_mn, cur_mx;
    assign cur_mn = (rf_go || rf_data < mn) ? rf_data : mn;
    assign cur_mx = (rf_go || rf_data > mx) ? rf_data : mx;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            active <= 1'b0; mn <= '0; mx <= '0; rf_range <= '0; rf_error <= 1'b0;
        end else begin
            if (rf_go || active) begin
                mn <= cur_mn;
                mx <= cur_mx;
            end
            if (rf_finish) begin
                rf_range <= {1'b0, cur_mx} - {1'b0, cur_mn};
                rf_error <= err_inject;
                active   <= 1'b0;
            end else if (rf_go) begin
                active <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on each result handshake
    always @(negedge clock) begin
        if (!reset && r_valid && r_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("r_range", 32'(r_range), 32'(e.range));
                chk("r_count", 32'(r_count), 32'(e.count));
                chk("r_trunc", 32'(r_trunc), 32'(e.trunc));
                chk("r_err",   32'(r_err),   32'(e.err));
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic go, input logic fin, input string tag);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clock);
        chk({tag, "_s_ready"}, 32'(s_ready), 1);
        chk({tag, "_go"}, 32'(rf_go), 32'(go));
        chk({tag, "_finish"}, 32'(rf_finish), 32'(fin));
        chk({tag, "_data"}, 32'(rf_data), 32'(d));
        tick();
        s_valid = 1'b0;
    endtask

    task automatic gap(input int n, input logic [WIDTH-1:0] hold, input string tag);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk({tag, "_hold_data"}, 32'(rf_data), 32'(hold));
            chk({tag, "_no_finish"}, 32'(rf_finish), 0);
            tick();
        end
    endtask

    task automatic drain(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clock);
            if (r_valid && r_ready) got = 1'b1;
            tick();
        end
        chk({tag, "_result_seen"}, 32'(got), 1);
    endtask

    task automatic push(input int rng, input int cnt, input logic tr, input logic er);
        res_t e;
        e.range = (WIDTH+1)'(rng);
        e.count = CW'(cnt);
        e.trunc = tr;
        e.err   = er;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fin_at;
        @(negedge clock);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_r_valid", 32'(r_valid), 0);
        chk("rst_rf_data", 32'(rf_data), 0);
        chk("rst_r_range", 32'(r_range), 0);
        chk("rst_r_count", 32'(r_count), 0);
        tick();
        reset = 1'b0;

        // nominal window
        cfg_len = 4; push(22, 4, 0, 0);
        send(10, 1, 0, "nom0"); send(3, 0, 0, "nom1");
        send(25, 0, 0, "nom2"); send(7, 0, 1, "nom3");
        @(negedge clock);
        chk("nom_wait_r_valid", 32'(r_valid), 0);
        chk("nom_wait_s_ready", 32'(s_ready), 0);
        tick();
        drain("nom");

        // gapped stream: data held across gaps
        cfg_len = 3; push(20, 3, 0, 0);
        send(50, 1, 0, "gap0"); gap(5, 50, "gapA");
        send(60, 0, 0, "gap1"); gap(2, 60, "gapB");
        send(40, 0, 1, "gap2"); drain("gap");

        // idle timeout
        cfg_len = 8; push(4, 2, 1, 0);
        send(5, 1, 0, "tmo0"); send(9, 0, 0, "tmo1");
        fin_at = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (rf_finish) begin
                fin_at = k;
                chk("tmo_held_data", 32'(rf_data), 9);
                break;
            end
            tick();
        end
        chk("tmo_finish_delay", 32'(fin_at), 63);
        tick();
        drain("tmo");

        // zero length behaves as one; error flag captured
        cfg_len = 0; push(0, 1, 0, 0);
        send(17, 1, 1, "len0"); drain("len0");
        cfg_len = 1; err_inject = 1'b1; push(0, 1, 0, 1);
        send(200, 1, 1, "err"); drain("err");
        err_inject = 1'b0;

        // over-long length clamps to MAX_LEN
        cfg_len = CW'(MAX_LEN + 5); push(27, MAX_LEN, 0, 0);
        for (int i = 0; i < MAX_LEN; i++)
            send(WIDTH'(i * 3), i == 0, i == MAX_LEN - 1, "clamp");
        drain("clamp");

        // backpressure: result held stable
        r_ready = 1'b0; cfg_len = 2; push(60, 2, 0, 0);
        send(100, 1, 0, "bp0"); send(40, 0, 1, "bp1");
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_r_valid", 32'(r_valid), 1);
            chk("bp_s_ready", 32'(s_ready), 0);
            chk("bp_r_range", 32'(r_range), 60);
            chk("bp_r_count", 32'(r_count), 2);
            tick();
        end
        r_ready = 1'b1;
        drain("bp");

        // abort mid-window rejects the concurrent sample
        cfg_len = 8; push(7, 3, 1, 0);
        send(1, 1, 0, "ab0"); send(2, 0, 0, "ab1"); send(8, 0, 0, "ab2");
        abort = 1'b1; s_valid = 1'b1; s_data = 99;
        @(negedge clock);
        chk("ab_s_ready", 32'(s_ready), 0);
        chk("ab_finish", 32'(rf_finish), 1);
        chk("ab_held_data", 32'(rf_data), 8);
        tick();
        abort = 1'b0; s_valid = 1'b0;
        drain("ab");

        // abort coinciding with the final sample: sample taken, truncated
        cfg_len = 2; push(7, 2, 1, 0);
        send(5, 1, 0, "abf0");
        abort = 1'b1;
        send(12, 0, 1, "abf1");
        abort = 1'b0;
        drain("abf");

        // final sample on the timeout cycle wins, not truncated
        cfg_len = 2; push(3, 2, 0, 0);
        send(30, 1, 0, "tf0"); gap(TIMEOUT - 1, 30, "tfgap");
        send(33, 0, 1, "tf1"); drain("tf");

        // async reset mid-RUN between edges
        cfg_len = 5;
        send(1, 1, 0, "rs0"); send(2, 0, 0, "rs1");
        s_valid = 1'b1; s_data = 3;
        #2 reset = 1'b1;
        #1;
        chk("rs_rf_go", 32'(rf_go), 0);
        chk("rs_rf_finish", 32'(rf_finish), 0);
        chk("rs_r_valid", 32'(r_valid), 0);
        chk("rs_s_ready", 32'(s_ready), 0);
        chk("rs_rf_data", 32'(rf_data), 0);
        tick();
        reset = 1'b0; s_valid = 1'b0;
        @(negedge clock);
        chk("rs_idle_s_ready", 32'(s_ready), 1);
        tick();
        cfg_len = 2; push(2, 2, 0, 0);
        send(4, 1, 0, "post0"); send(6, 0, 1, "post1"); drain("post");

        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
